// File: rtl/world_gen_buf.sv
// Double-buffered Game of Life world store.
// Two bit-per-cell banks: the current bank is read combinationally with a
// signed neighbour offset, and the next bank is written by the update
// engine. A swap pulse exchanges the two banks. Population counters are
// maintained incrementally, and a sequencer zeroes banks one cell per
// cycle: both banks after reset, and only the next bank on request.
//
// Control pulses (we, swap, clear) are sampled on the rising edge and
// act only while busy is low. While a clear sequence runs they are
// dropped, not queued.
module world_gen_buf #(
  parameter int ROW_BITS = 6,
  parameter int COL_BITS = 6,
  parameter bit WRAP     = 1'b1,
  parameter int GEN_BITS = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ROW_BITS-1:0]          row,
  input  logic [COL_BITS-1:0]          col,
  input  logic [1:0]                   dr,
  input  logic [1:0]                   dc,
  input  logic                         we,
  input  logic                         in,
  input  logic                         swap,
  input  logic                         clear,
  output logic                         out,
  output logic                         busy,
  output logic [ROW_BITS+COL_BITS:0]   cur_pop,
  output logic [ROW_BITS+COL_BITS:0]   next_pop,
  output logic [GEN_BITS-1:0]          gen
);

  localparam int AW    = ROW_BITS + COL_BITS;
  localparam int PB    = AW + 1;
  localparam int RW    = ROW_BITS + 1;
  localparam int CW    = COL_BITS + 1;
  localparam int CELLS = 1 << AW;
  localparam logic [PB-1:0] POP_MAX   = PB'(CELLS);
  localparam logic [AW-1:0] ADDR_LAST = '1;

  // ST_DUAL: post-reset zeroing of both banks; ST_CLEAR: next bank only.
  typedef enum logic [1:0] {
    ST_DUAL  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [AW-1:0]     clr_addr, clr_addr_nx;
  logic              sel, sel_nx;        // 0: bank0 is current, 1: bank1 is current
  logic [PB-1:0]     cur_nx, nxt_nx, pop_w;
  logic [GEN_BITS-1:0] gen_nx;

  logic              bank0 [CELLS];
  logic              bank1 [CELLS];

  logic [RW-1:0]     row_off, row_sum;
  logic [CW-1:0]     col_off, col_sum;
  logic [AW-1:0]     rd_addr, wr_addr;
  logic              outside, cur_bit, old_w, old_clr;

  assign busy    = (state != ST_IDLE);
  assign wr_addr = {row, col};

  // Decode the 2-bit signed offsets; 2'b10 is treated as zero.
  always_comb begin
    row_off = '0;
    col_off = '0;
    case (dr)
      2'b11:   row_off = '1;
      2'b01:   row_off = RW'(1);
      default: row_off = '0;
    endcase
    case (dc)
      2'b11:   col_off = '1;
      2'b01:   col_off = CW'(1);
      default: col_off = '0;
    endcase
  end

  // Effective read address and current-bank read; one extra bit catches
  // both -1 and ROWS/COLS, which matters only for dead-boundary edges.
  always_comb begin
    row_sum = {1'b0, row} + row_off;
    col_sum = {1'b0, col} + col_off;
    rd_addr = {row_sum[ROW_BITS-1:0], col_sum[COL_BITS-1:0]};
    outside = WRAP ? 1'b0 : (row_sum[ROW_BITS] | col_sum[COL_BITS]);
    cur_bit = sel ? bank1[rd_addr] : bank0[rd_addr];
    out     = cur_bit & ~outside;
  end

  // Old next-bank values at the write address and the clear address.
  always_comb begin
    old_w   = sel ? bank0[wr_addr]  : bank1[wr_addr];
    old_clr = sel ? bank0[clr_addr] : bank1[clr_addr];
  end

  // Next-state and counter logic for the clear sequencer, writes and swaps.
  always_comb begin
    state_nx    = state;
    clr_addr_nx = clr_addr;
    sel_nx      = sel;
    cur_nx      = cur_pop;
    nxt_nx      = next_pop;
    gen_nx      = gen;
    pop_w       = next_pop;
    case (state)
      ST_DUAL: begin
        clr_addr_nx = clr_addr + AW'(1);
        if (clr_addr == ADDR_LAST) state_nx = ST_IDLE;
      end
      ST_CLEAR: begin
        if (old_clr && (next_pop != '0)) nxt_nx = next_pop - PB'(1);
        clr_addr_nx = clr_addr + AW'(1);
        if (clr_addr == ADDR_LAST) state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        // The write is accounted first so a same-edge swap carries it over.
        if (we) begin
          if (!old_w && in && (pop_w != POP_MAX))   pop_w = next_pop + PB'(1);
          else if (old_w && !in && (pop_w != '0))   pop_w = next_pop - PB'(1);
        end
        nxt_nx = pop_w;
        if (clear) begin
          state_nx    = ST_CLEAR;
          clr_addr_nx = '0;
        end else if (swap) begin
          sel_nx = ~sel;
          cur_nx = pop_w;
          nxt_nx = cur_pop;
          gen_nx = gen + GEN_BITS'(1);
        end
      end
      default: state_nx = ST_DUAL;
    endcase
  end

  // Control state register with asynchronous reset into the dual clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_DUAL;
      clr_addr <= '0;
      sel      <= 1'b0;
      cur_pop  <= '0;
      next_pop <= '0;
      gen      <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_addr_nx;
      sel      <= sel_nx;
      cur_pop  <= cur_nx;
      next_pop <= nxt_nx;
      gen      <= gen_nx;
    end
  end

  // Cell storage: clear sequencer has priority, otherwise the engine write
  // goes to whichever bank is currently the next bank.
  always_ff @(posedge clk) begin
    if (state == ST_DUAL) begin
      bank0[clr_addr] <= 1'b0;
      bank1[clr_addr] <= 1'b0;
    end else if (state == ST_CLEAR) begin
      if (sel) bank0[clr_addr] <= 1'b0;
      else     bank1[clr_addr] <= 1'b0;
    end else if (we) begin
      if (sel) bank0[wr_addr] <= in;
      else     bank1[wr_addr] <= in;
    end
  end

endmodule

// File: tb/tb_world_gen_buf.sv
// Testbench for world_gen_buf: a toroidal and a dead-boundary instance
// share the same stimulus. Directed vectors push expected values into a
// queue, and a monitor pops and compares them on the falling edge.
module tb_world_gen_buf;

  localparam int RB = 6;
  localparam int CB = 6;
  localparam int PB = RB + CB + 1;
  localparam int GB = 16;

  // Expected-entry kinds
  localparam logic [3:0] K_OUT   = 4'd0;
  localparam logic [3:0] K_OUTNW = 4'd1;
  localparam logic [3:0] K_BUSY  = 4'd2;
  localparam logic [3:0] K_CPOP  = 4'd3;
  localparam logic [3:0] K_NPOP  = 4'd4;
  localparam logic [3:0] K_GEN   = 4'd5;
  localparam logic [3:0] K_BLEN  = 4'd6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RB-1:0] row = '0;
  logic [CB-1:0] col = '0;
  logic [1:0]    dr = 2'b00, dc = 2'b00;
  logic          we = 1'b0, in = 1'b0, swap = 1'b0, clear = 1'b0;

  logic          out_w, busy_w, out_n, busy_n;
  logic [PB-1:0] cpop_w, npop_w, cpop_n, npop_n;
  logic [GB-1:0] gen_w, gen_n;

  logic [35:0]   exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            busy_len = 0;

  // Clock/reset block
  always #5 clk = ~clk;

  world_gen_buf #(.ROW_BITS(RB), .COL_BITS(CB), .WRAP(1'b1), .GEN_BITS(GB)) u_wrap (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .dr(dr), .dc(dc),
    .we(we), .in(in), .swap(swap), .clear(clear),
    .out(out_w), .busy(busy_w), .cur_pop(cpop_w), .next_pop(npop_w), .gen(gen_w)
  );

  world_gen_buf #(.ROW_BITS(RB), .COL_BITS(CB), .WRAP(1'b0), .GEN_BITS(GB)) u_nowrap (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .dr(dr), .dc(dc),
    .we(we), .in(in), .swap(swap), .clear(clear),
    .out(out_n), .busy(busy_n), .cur_pop(cpop_n), .next_pop(npop_n), .gen(gen_n)
  );

  function automatic string kind_name(input logic [3:0] k);
    case (k)
      K_OUT:   return "out_wrap";
      K_OUTNW: return "out_nowrap";
      K_BUSY:  return "busy";
      K_CPOP:  return "cur_pop";
      K_NPOP:  return "next_pop";
      K_GEN:   return "gen";
      K_BLEN:  return "busy_cycles";
      default: return "unknown";
    endcase
  endfunction

  // Scoreboard monitor: drain all pending expectations at each falling edge
  always @(negedge clk) begin
    logic [35:0] e;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e[35:32])
        K_OUT:   act = 32'(out_w);
        K_OUTNW: act = 32'(out_n);
        K_BUSY:  act = 32'(busy_w);
        K_CPOP:  act = 32'(cpop_w);
        K_NPOP:  act = 32'(npop_w);
        K_GEN:   act = 32'(gen_w);
        K_BLEN:  act = 32'(busy_len);
        default: act = 32'hdead_beef;
      endcase
      total++;
      if (act !== e[31:0]) begin
        bad++;
        $display("FAIL %s: got %0d expected %0d at %0t", kind_name(e[35:32]), act, e[31:0], $time);
      end
    end
  end

  // Driver tasks
  task automatic push(input logic [3:0] k, input int v);
    exp_q.push_back({k, 32'(v)});
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    we = 1'b0;
    swap = 1'b0;
    clear = 1'b0;
  endtask

  task automatic wr(input int r, input int c, input logic v);
    row = RB'(r); col = CB'(c); dr = 2'b00; dc = 2'b00;
    in = v; we = 1'b1;
    step();
  endtask

  task automatic chk_out(input int r, input int c, input logic [1:0] odr,
                         input logic [1:0] odc, input int e_wrap, input int e_nw);
    row = RB'(r); col = CB'(c); dr = odr; dc = odc;
    push(K_OUT, e_wrap);
    push(K_OUTNW, e_nw);
    sync();
  endtask

  task automatic chk_cnt(input int cp, input int np, input int g, input int b);
    push(K_CPOP, cp);
    push(K_NPOP, np);
    push(K_GEN, g);
    push(K_BUSY, b);
    sync();
  endtask

  // Counts rising edges until busy drops, bounded so a stuck busy fails.
  task automatic measure_busy(input int already);
    int n;
    n = already;
    while (busy_w && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    busy_len = n;
    push(K_BLEN, 4096);
    sync();
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt(0, 0, 0, 1);

    // Release: dual clear runs 4096 cycles, then the world is empty
    rst_n = 1'b1;
    measure_busy(0);
    chk_cnt(0, 0, 0, 0);
    chk_out(0, 0, 2'b00, 2'b00, 0, 0);
    chk_out(63, 63, 2'b00, 2'b00, 0, 0);

    // Write (5,7): only next bank changes; swap exposes it
    wr(5, 7, 1'b1);
    chk_cnt(0, 1, 0, 0);
    chk_out(5, 7, 2'b00, 2'b00, 0, 0);
    swap = 1'b1;
    step();
    chk_out(5, 7, 2'b00, 2'b00, 1, 1);
    chk_cnt(1, 0, 1, 0);

    // Current (0,0)=1; next bank then holds (5,7)
    wr(0, 0, 1'b1);
    swap = 1'b1;
    step();
    chk_cnt(1, 1, 2, 0);
    chk_out(63, 63, 2'b01, 2'b01, 1, 0);   // wraps onto (0,0)
    chk_out(0, 1, 2'b00, 2'b11, 1, 1);     // left neighbour in range
    chk_out(1, 0, 2'b11, 2'b00, 1, 1);     // upper neighbour in range
    chk_out(0, 0, 2'b10, 2'b10, 1, 1);     // 2'b10 offset means zero
    chk_out(0, 0, 2'b11, 2'b00, 0, 0);     // (63,0) is empty / outside
    chk_out(5, 7, 2'b00, 2'b00, 0, 0);     // now in the next bank

    // Repeated writes to (3,3) on top of (5,7) already in next bank
    wr(3, 3, 1'b1);
    chk_cnt(1, 2, 2, 0);
    wr(3, 3, 1'b1);
    chk_cnt(1, 2, 2, 0);
    wr(3, 3, 1'b0);
    chk_cnt(1, 1, 2, 0);

    // Swap and write on the same edge
    swap = 1'b1;
    wr(9, 9, 1'b1);
    chk_out(9, 9, 2'b00, 2'b00, 1, 1);
    chk_out(5, 7, 2'b00, 2'b00, 1, 1);
    chk_out(0, 0, 2'b00, 2'b00, 0, 0);
    chk_cnt(2, 1, 3, 0);

    // Fill next bank to 10 live cells ((0,0) plus nine more)
    for (int i = 0; i < 9; i++) wr(10, i, 1'b1);
    chk_cnt(2, 10, 3, 0);

    // Clear; we and swap during busy must be ignored
    clear = 1'b1;
    step();
    chk_cnt(2, 10, 3, 1);
    wr(20, 20, 1'b1);
    swap = 1'b1;
    step();
    measure_busy(2);
    chk_cnt(2, 0, 3, 0);
    swap = 1'b1;
    step();
    chk_out(20, 20, 2'b00, 2'b00, 0, 0);
    chk_out(10, 3, 2'b00, 2'b00, 0, 0);
    chk_cnt(0, 2, 4, 0);

    // clear + swap + we in one idle cycle: write lands, swap dropped
    clear = 1'b1;
    swap = 1'b1;
    wr(1, 1, 1'b1);
    chk_cnt(0, 3, 4, 1);
    measure_busy(0);
    chk_cnt(0, 0, 4, 0);

    // Build nonzero state, then reset in the middle of a clear
    wr(2, 2, 1'b1);
    swap = 1'b1;
    step();
    wr(4, 4, 1'b1);
    chk_cnt(1, 1, 5, 0);
    chk_out(2, 2, 2'b00, 2'b00, 1, 1);
    clear = 1'b1;
    step();
    repeat (999) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_cnt(0, 0, 0, 1);
    repeat (2) @(posedge clk);
    sync();
    rst_n = 1'b1;
    measure_busy(0);
    chk_cnt(0, 0, 0, 0);
    chk_out(2, 2, 2'b00, 2'b00, 0, 0);

    // Final report
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
